// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and data-memory wait control for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_cnt_nx;
    logic          load_use, mem_wait, wait_last;

    assign load_use  = ex_mem_read & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign mem_wait  = mem_access & ~dmem_ready;
    assign wait_last = wait_cnt == WW'(TIMEOUT - 1);

    // state register and wait counter; reset drops any wait in progress or a latched error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // next state: WAIT counts cycles until ready, or gives up into terminal ERR
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        case (state)
            RUN: begin
                state_nx    = mem_wait ? WAIT : RUN;
                wait_cnt_nx = '0;
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_last) begin
                    state_nx    = ERR;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            ERR: begin
                state_nx    = ERR;
                wait_cnt_nx = '0;
            end
            default: begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

    // pipeline controls by priority: error, memory wait, taken branch, load-use, normal
    always_comb begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b0;
        end else if (state == ERR) begin
            pipe_freeze = 1'b1;
            mem_timeout = 1'b1;
        end else if (mem_wait) begin
            pipe_freeze = 1'b1;
        end else if (mem_branch_taken) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (load_use) begin
            id_ex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    // saturating counters of stall cycles and branch flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] NRM  = 7'b1100000;
    localparam logic [6:0] LU   = 7'b0001000;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] FRZ  = 7'b0000010;
    localparam logic [6:0] ERRV = 7'b0000011;
    localparam logic [6:0] RSTV = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
    logic        mem_access = 1'b0, dmem_ready = 1'b0;
    logic        pw0, iw0, fl0, ib0, eb0, fz0, mt0;
    logic        pw1, iw1, fl1, ib1, eb1, fz1, mt1;
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
    logic [6:0]  q[$];
    logic [15:0] es0 = '0, ef0 = '0;
    logic [3:0]  es1 = '0, ef1 = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_write(pw0), .if_id_write(iw0),
        .if_id_flush(fl0), .id_ex_bubble(ib0), .ex_mem_bubble(eb0), .pipe_freeze(fz0),
        .mem_timeout(mt0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_write(pw1), .if_id_write(iw1),
        .if_id_flush(fl1), .id_ex_bubble(ib1), .ex_mem_bubble(eb1), .pipe_freeze(fz1),
        .mem_timeout(mt1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        logic [6:0] e;
        e = q.pop_front();
        chk({tag, ".out0"}, {25'd0, pw0, iw0, fl0, ib0, eb0, fz0, mt0}, {25'd0, e});
        chk({tag, ".out1"}, {25'd0, pw1, iw1, fl1, ib1, eb1, fz1, mt1}, {25'd0, e});
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".stall0"}, {16'd0, sc0}, {16'd0, es0});
        chk({tag, ".flush0"}, {16'd0, fc0}, {16'd0, ef0});
        chk({tag, ".stall1"}, {28'd0, sc1}, {28'd0, es1});
        chk({tag, ".flush1"}, {28'd0, fc1}, {28'd0, ef1});
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic emr, input logic [4:0] ert, input logic br,
                        input logic ma, input logic rdy, input logic [6:0] exp,
                        input string tag);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = emr; ex_rt = ert;
        mem_branch_taken = br; mem_access = ma; dmem_ready = rdy;
        q.push_back(exp);
        @(negedge clk);
        chk_out(tag);
        if (!exp[6]) begin
            es0 = (es0 == 16'hFFFF) ? es0 : es0 + 16'd1;
            es1 = (es1 == 4'hF) ? es1 : es1 + 4'd1;
        end
        if (exp[4]) begin
            ef0 = (ef0 == 16'hFFFF) ? ef0 : ef0 + 16'd1;
            ef1 = (ef1 == 4'hF) ? ef1 : ef1 + 4'd1;
        end
        @(posedge clk);
        #1;
        chk_cnt(tag);
    endtask

    task automatic rst_pulse(input string tag);
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
        rst_n = 1'b0;
        q.push_back(RSTV);
        #1;
        es0 = '0; ef0 = '0; es1 = '0; ef1 = '0;
        chk_out(tag);
        chk_cnt({tag, ".async"});
        @(posedge clk);
        #1;
        chk_cnt({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        q.push_back(RSTV);
        chk_out("reset");
        chk_cnt("reset");
        @(posedge clk);
        #1;
        chk_cnt("reset_held");
        rst_n = 1'b1;
        step(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, "normal");
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU,  "lu_rs");
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, "lu_after");
        step(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU,  "lu_rt");
        step(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, NRM, "lu_rt_unused");
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NRM, "lu_r0");
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, NRM, "no_load");
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, BR,  "br_over_lu");
        step(5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR,  "br");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, "wait1");
        step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, FRZ, "wait2_ignore");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, "wait3");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, "wait_done");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, "back_run");
        for (int i = 0; i < 5; i++)
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, "to_wait");
        for (int i = 0; i < 20; i++)
            step(5'd8, 5'd2, 1'b0, 1'b1, 5'd8, i[0], 1'b0, 1'b1, ERRV, "err_sticky");
        rst_pulse("rst_err");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NRM, "after_rst");
        for (int i = 0; i < 3; i++)
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, "pre_rst_wait");
        rst_pulse("rst_wait");
        for (int i = 0; i < 4; i++)
            step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, "edge_wait");
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NRM, "edge_ready");
        step(5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR,  "br_final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of performance counters.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_rs  input  5  rs of instruction in ID.
REQ-006 SHALL have port id_rt  input  5  rt of instruction in ID.
REQ-007 SHALL have port id_uses_rt  input  1  ID instruction reads rt.
REQ-008 SHALL have port ex_mem_read  input  1  mem_read of instruction in EX (ID/EX output).
REQ-009 SHALL have port ex_rt  input  5  rt of instruction in EX (ID/EX output).
REQ-010 SHALL have port mem_branch_taken  input  1  branch resolved taken in MEM.
REQ-011 SHALL have port mem_access  input  1  MEM-stage instruction reads or writes data memory.
REQ-012 SHALL have port dmem_ready  input  1  data memory completes access this cycle.
REQ-013 SHALL have port pc_write  output  1  PC load enable.
REQ-014 SHALL have port if_id_write  output  1  IF/ID load enable.
REQ-015 SHALL have port if_id_flush  output  1  IF/ID loads NOP.
REQ-016 SHALL have port id_ex_bubble  output  1  ID/EX loads all-zero control fields.
REQ-017 SHALL have port ex_mem_bubble  output  1  EX/MEM loads all-zero control fields.
REQ-018 SHALL have port pipe_freeze  output  1  ID/EX, EX/MEM hold; MEM/WB loads bubble.
REQ-019 SHALL have port mem_timeout  output  1  sticky wait-timeout error.
REQ-020 SHALL have port stall_cnt  output  CNT_W  cycles with pc_write=0 outside reset.
REQ-021 SHALL have port flush_cnt  output  CNT_W  branch flushes taken.

Function
REQ-022 SHALL compute load_use = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-023 SHALL compute mem_wait = mem_access & ~dmem_ready.
REQ-024 SHALL implement FSM states RUN, WAIT, ERR; 2-bit state register.
REQ-025 RUN: mem_wait -> WAIT next edge, else stay RUN.
REQ-026 WAIT: dmem_ready -> RUN; wait_cnt==TIMEOUT-1 and ~dmem_ready -> ERR; else stay WAIT, wait_cnt+1.
REQ-027 wait_cnt SHALL clear on entry to WAIT and on exit; count cycles spent in WAIT.
REQ-028 ERR SHALL be terminal until rst_n asserted.
REQ-029 Outputs SHALL be combinational from state and inputs, priority: ERR > mem_wait > mem_branch_taken > load_use > normal.
REQ-030 ERR: pipe_freeze=1, pc_write=0, if_id_write=0, flush/bubble outputs 0, mem_timeout=1.
REQ-031 mem_wait (RUN or WAIT): pipe_freeze=1, pc_write=0, if_id_write=0, branch/load-use ignored that cycle.
REQ-032 mem_branch_taken (no wait): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1; load_use ignored.
REQ-033 load_use only: pc_write=0, if_id_write=0, id_ex_bubble=1; exactly one bubble per hazard.
REQ-034 Normal: pc_write=1, if_id_write=1, all others 0.
REQ-035 stall_cnt SHALL increment on each clock edge where pc_write=0; saturate at all-ones.
REQ-036 flush_cnt SHALL increment on each edge where REQ-032 applies; saturate at all-ones.

Reset
REQ-037 rst_n low SHALL immediately force state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-038 While rst_n low, pc_write=0, if_id_write=0, all flush/bubble/freeze outputs 0; counters do not count.
REQ-039 Reset asserted mid-WAIT or in ERR SHALL return to RUN with no residual wait count.

Verification
REQ-040 ex_mem_read=1, ex_rt=8, id_rs=8 one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0->1.
REQ-041 ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall, pc_write=1.
REQ-042 load_use and mem_branch_taken same cycle -> flush wins: if_id_flush=1, pc_write=1, flush_cnt+1, stall_cnt unchanged.
REQ-043 mem_access=1, dmem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 3 cycles, state RUN->WAIT->RUN, stall_cnt=3, mem_timeout=0.
REQ-044 TIMEOUT=4, dmem_ready held 0 -> ERR after cycle 4 of wait, mem_timeout=1 sticky; rst_n pulse low -> RUN, all counters 0.
REQ-045 stall_cnt preloaded to 0xFFFF via sustained stall -> remains 0xFFFF on further stalls.
